// File: rtl/invert.sv
// Serial LSB-first two's-complement negator (Mealy, zero latency).
// Optional word counter and word_end port: define INVERT_WORD_CNT_EN.
module invert #(
  parameter int WORD_LEN = 0
) (
  input  logic x,
  input  logic r,
  input  logic t_clock,
  output logic y
`ifdef INVERT_WORD_CNT_EN
  ,
  output logic word_end
`endif
);

  typedef enum logic {
    S_COPY = 1'b0,
    S_INV  = 1'b1
  } state_t;

  state_t state;

  always_comb begin
    y = 1'b0;
    if (!r) begin
      unique case (state)
        S_COPY:  y = x;
        S_INV:   y = ~x;
        default: y = 1'b0;
      endcase
    end
  end

`ifdef INVERT_WORD_CNT_EN
  localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (WORD_LEN > 0) ? CW'(WORD_LEN - 1) : '0;
  localparam logic CNT_ON = (WORD_LEN > 0);

  logic [CW-1:0] cnt;
  logic          last;

  // a bit taken during reset is discarded, so it never ends a word
  assign last     = CNT_ON && !r && (cnt == CNT_LAST);
  assign word_end = last;

  always_ff @(posedge t_clock) begin
    if (r) begin
      state <= S_COPY;
      cnt   <= '0;
    end else if (last) begin
      state <= S_COPY;
      cnt   <= '0;
    end else begin
      if (x)
        state <= S_INV;
      if (CNT_ON)
        cnt <= cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge t_clock) begin
    if (r)
      state <= S_COPY;
    else if (x)
      state <= S_INV;
  end
`endif

endmodule

// File: tb/tb_invert.sv
// Self-checking bench for invert: fixed vectors plus random
// stimulus against an arithmetic (2^N - v) mod 2^N model.
module tb_invert;

`ifdef INVERT_WORD_CNT_EN
  localparam int WL = 4;
`else
  localparam int WL = 0;
`endif

  logic t_clock;
  logic x;
  logic r;
  logic y;
`ifdef INVERT_WORD_CNT_EN
  logic word_end;
`endif

  int n_cmp;
  int n_bad;

  logic [63:0] acc;
  int          idx;
  logic        exp_y;
  logic        exp_we;

  invert #(.WORD_LEN(WL)) dut (
    .x(x),
    .r(r),
    .t_clock(t_clock),
    .y(y)
`ifdef INVERT_WORD_CNT_EN
    ,
    .word_end(word_end)
`endif
  );

  initial t_clock = 1'b0;
  always #5 t_clock = ~t_clock;

  // Advance one bit: commit previous bit to the model at the edge,
  // apply the new bit, predict outputs, and settle to the negedge.
  task automatic step(input logic xi, input logic ri);
    logic [63:0] v;
    logic [63:0] nv;
    @(posedge t_clock);
    if (r) begin
      acc = '0;
      idx = 0;
    end else begin
      if (idx < 64) acc[idx] = x;
      idx++;
      if (WL > 0 && idx == WL) begin
        acc = '0;
        idx = 0;
      end
    end
    #1;
    x = xi;
    r = ri;
    v = acc;
    if (idx < 64) v[idx] = xi;
    nv = ~v + 64'd1;
    exp_y  = ri ? 1'b0 : nv[idx % 64];
    exp_we = !ri && (WL > 0) && (idx == WL - 1);
    @(negedge t_clock);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1);
    n_cmp++;
    if (y !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_x1: y=%b want 0", y);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (y !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_x0: y=%b want 0", y);
    end
  endtask

  task automatic test_value10;
    logic [3:0] xs;
    logic [3:0] ys;
    xs = 4'b1010;
    ys = 4'b0110;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(xs[i], 1'b0);
      n_cmp++;
      if (y !== ys[i]) begin
        n_bad++;
        $display("FAIL value10 bit%0d: y=%b want %b", i, y, ys[i]);
      end
    end
  endtask

  task automatic test_value15;
    logic [3:0] ys;
    ys = 4'b0001;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (y !== ys[i]) begin
        n_bad++;
        $display("FAIL value15 bit%0d: y=%b want %b", i, y, ys[i]);
      end
    end
  endtask

  task automatic test_zero;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (y !== 1'b0) begin
        n_bad++;
        $display("FAIL zero bit%0d: y=%b want 0", i, y);
      end
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (y !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_rst: y=%b want 0", y);
    end
  endtask

  task automatic test_mid_reset;
    logic [4:0] xs;
    logic [4:0] rs;
    logic [4:0] ys;
    xs = 5'b10101;
    rs = 5'b00100;
    ys = 5'b10011;
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(xs[i], rs[i]);
      n_cmp++;
      if (y !== ys[i]) begin
        n_bad++;
        $display("FAIL mid_reset bit%0d: y=%b want %b", i, y, ys[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xs;
    logic [7:0] ys;
    logic [7:0] ws;
    xs = 8'b1111_1010;
`ifdef INVERT_WORD_CNT_EN
    ys = 8'b0001_0110;
`else
    ys = 8'b0000_0110;
`endif
    ws = 8'b1000_1000;
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(xs[i], 1'b0);
      n_cmp++;
      if (y !== ys[i]) begin
        n_bad++;
        $display("FAIL b2b bit%0d: y=%b want %b", i, y, ys[i]);
      end
`ifdef INVERT_WORD_CNT_EN
      n_cmp++;
      if (word_end !== ws[i]) begin
        n_bad++;
        $display("FAIL b2b_we bit%0d: word_end=%b want %b",
                 i, word_end, ws[i]);
      end
`else
      if (ws[i] === 1'bx) $display("unexpected x in table");
`endif
    end
  endtask

  task automatic test_reset_on_last;
    logic [7:0] xs;
    logic [7:0] rs;
    logic [7:0] ys;
    logic [7:0] ws;
    xs = 8'b0110_1101;
    rs = 8'b0000_1000;
    ys = 8'b1010_0011;
    ws = 8'b1000_0000;
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(xs[i], rs[i]);
      n_cmp++;
      if (y !== ys[i]) begin
        n_bad++;
        $display("FAIL rst_last bit%0d: y=%b want %b", i, y, ys[i]);
      end
`ifdef INVERT_WORD_CNT_EN
      if (!rs[i]) begin
        n_cmp++;
        if (word_end !== ws[i]) begin
          n_bad++;
          $display("FAIL rst_last_we bit%0d: word_end=%b want %b",
                   i, word_end, ws[i]);
        end
      end
`else
      if (ws[i] === 1'bx) $display("unexpected x in table");
`endif
    end
  endtask

  task automatic test_random;
    logic xi;
    logic ri;
    step(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      ri = ($urandom_range(0, 19) == 0) || (WL == 0 && idx >= 60);
      xi = 1'($urandom_range(0, 1));
      step(xi, ri);
      n_cmp++;
      if (y !== exp_y) begin
        n_bad++;
        $display("FAIL random y #%0d: y=%b want %b (x=%b r=%b)",
                 i, y, exp_y, xi, ri);
      end
`ifdef INVERT_WORD_CNT_EN
      n_cmp++;
      if (word_end !== exp_we) begin
        n_bad++;
        $display("FAIL random we #%0d: word_end=%b want %b",
                 i, word_end, exp_we);
      end
`endif
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    acc   = '0;
    idx   = 0;
    x     = 1'b0;
    r     = 1'b1;
    test_reset();
    test_value10();
    test_value15();
    test_zero();
    test_mid_reset();
    test_back_to_back();
    test_reset_on_last();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
